// File: rtl/qspi_pkg.sv
// Shared types and constants for the QSPI transfer arbiter.
// Holds FSM state codes, owner enum, payload widths and XIP opcode.
package qspi_pkg;

    localparam int CMD_W  = 8;
    localparam int ADDR_W = 32;
    localparam int LEN_W  = 8;
    localparam int TO_W   = 16;
    localparam int GAP_W  = 4;

    localparam logic [CMD_W-1:0] XIP_CMD_DEF = 8'hEB;

    localparam logic [2:0] ST_IDLE     = 3'd0;
    localparam logic [2:0] ST_LAUNCH   = 3'd1;
    localparam logic [2:0] ST_WAIT_ACK = 3'd2;
    localparam logic [2:0] ST_ACTIVE   = 3'd3;
    localparam logic [2:0] ST_GAP      = 3'd4;

    typedef enum logic {
        OWN_XIP = 1'b0,
        OWN_IND = 1'b1
    } owner_e;

endpackage

// File: rtl/qspi_rr_arb.sv
// Two-way round-robin arbiter between XIP (bit 0) and indirect (bit 1).
// Ports: clk_i/rst_i, req_i[1:0], advance_i (commit winner), gnt_onehot_o[1:0].
module qspi_rr_arb
    import qspi_pkg::*;
(
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic [1:0] req_i,
    input  logic       advance_i,
    output logic [1:0] gnt_onehot_o
);

    owner_e last_q;
    owner_e last_d;

    always_comb begin
        gnt_onehot_o = 2'b00;
        case (req_i)
            2'b01:   gnt_onehot_o = 2'b01;
            2'b10:   gnt_onehot_o = 2'b10;
            // On a tie the side not served last wins.
            2'b11:   gnt_onehot_o = (last_q == OWN_IND) ? 2'b01 : 2'b10;
            default: gnt_onehot_o = 2'b00;
        endcase
    end

    always_comb begin
        last_d = last_q;
        if (advance_i && gnt_onehot_o[0]) begin
            last_d = OWN_XIP;
        end else if (advance_i && gnt_onehot_o[1]) begin
            last_d = OWN_IND;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            last_q <= OWN_IND;
        end else begin
            last_q <= last_d;
        end
    end

endmodule

// File: rtl/qspi_xfer_arbiter.sv
// Arbitrates XIP reads and indirect commands onto one QSPI sequencer.
// Ports: xip_*/ind_* request sides with gnt/done pulses, seq_* controller
// side (start/abort out, busy/done in), cs_gap/to_lim config, xfer_err.
module qspi_xfer_arbiter
    import qspi_pkg::*;
#(
    parameter logic [CMD_W-1:0] XIP_CMD = XIP_CMD_DEF
) (
    input  logic              h_clk,
    input  logic              h_rst,
    input  logic              xip_req,
    input  logic [ADDR_W-1:0] xip_addr,
    input  logic [LEN_W-1:0]  xip_len,
    input  logic              ind_req,
    input  logic [CMD_W-1:0]  ind_cmd,
    input  logic [ADDR_W-1:0] ind_addr,
    input  logic [LEN_W-1:0]  ind_len,
    output logic              xip_gnt,
    output logic              ind_gnt,
    output logic              xip_done,
    output logic              ind_done,
    output logic              xfer_err,
    output logic              seq_start,
    output logic [CMD_W-1:0]  seq_cmd,
    output logic [ADDR_W-1:0] seq_addr,
    output logic [LEN_W-1:0]  seq_len,
    input  logic              seq_busy,
    input  logic              seq_done,
    output logic              seq_abort,
    input  logic [GAP_W-1:0]  cs_gap,
    input  logic [TO_W-1:0]   to_lim
);

    logic [2:0]        state_q, state_d;
    owner_e            owner_q, owner_d;
    logic              xip_gnt_q, xip_gnt_d;
    logic              ind_gnt_q, ind_gnt_d;
    logic [CMD_W-1:0]  cmd_q, cmd_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [LEN_W-1:0]  len_q, len_d;
    logic [TO_W-1:0]   cnt_q, cnt_d;
    logic [TO_W-1:0]   lim_q, lim_d;
    logic [GAP_W-1:0]  gap_q, gap_d;

    logic [1:0] rr_req;
    logic [1:0] rr_gnt;
    logic       gnt_pend;
    logic       advance;
    logic       in_xfer;
    logic       done_hit;
    logic       tmo_hit;

    assign rr_req   = {ind_req, xip_req};
    assign gnt_pend = xip_gnt_q | ind_gnt_q;
    // Pick a winner only on a fresh IDLE cycle, not while the grant is out.
    assign advance  = (state_q == ST_IDLE) && !gnt_pend && (|rr_req);

    qspi_rr_arb u_rr (
        .clk_i        (h_clk),
        .rst_i        (h_rst),
        .req_i        (rr_req),
        .advance_i    (advance),
        .gnt_onehot_o (rr_gnt)
    );

    assign in_xfer  = (state_q == ST_WAIT_ACK) || (state_q == ST_ACTIVE);
    assign done_hit = in_xfer && seq_done;
    // Count is one behind the cycles spent waiting; done beats timeout.
    assign tmo_hit  = in_xfer && !seq_done && (lim_q != '0)
                      && ((cnt_q + TO_W'(1)) == lim_q);

    always_comb begin
        state_d   = state_q;
        owner_d   = owner_q;
        xip_gnt_d = 1'b0;
        ind_gnt_d = 1'b0;
        cmd_d     = cmd_q;
        addr_d    = addr_q;
        len_d     = len_q;
        cnt_d     = cnt_q;
        lim_d     = lim_q;
        gap_d     = gap_q;
        unique case (state_q)
            ST_IDLE: begin
                if (gnt_pend) begin
                    state_d = ST_LAUNCH;
                end else if (advance && rr_gnt[0]) begin
                    owner_d   = OWN_XIP;
                    xip_gnt_d = 1'b1;
                    cmd_d     = XIP_CMD;
                    addr_d    = xip_addr;
                    len_d     = xip_len;
                end else if (advance && rr_gnt[1]) begin
                    owner_d   = OWN_IND;
                    ind_gnt_d = 1'b1;
                    cmd_d     = ind_cmd;
                    addr_d    = ind_addr;
                    len_d     = ind_len;
                end
            end
            ST_LAUNCH: begin
                cnt_d   = '0;
                lim_d   = to_lim;
                state_d = ST_WAIT_ACK;
            end
            ST_WAIT_ACK, ST_ACTIVE: begin
                cnt_d = cnt_q + TO_W'(1);
                if (done_hit || tmo_hit) begin
                    gap_d   = cs_gap;
                    state_d = (cs_gap == '0) ? ST_IDLE : ST_GAP;
                end else if (state_q == ST_WAIT_ACK && seq_busy) begin
                    state_d = ST_ACTIVE;
                end
            end
            ST_GAP: begin
                if (gap_q <= GAP_W'(1)) begin
                    state_d = ST_IDLE;
                end else begin
                    gap_d = gap_q - GAP_W'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge h_clk) begin
        if (h_rst) begin
            state_q   <= ST_IDLE;
            owner_q   <= OWN_XIP;
            xip_gnt_q <= 1'b0;
            ind_gnt_q <= 1'b0;
            cmd_q     <= '0;
            addr_q    <= '0;
            len_q     <= '0;
            cnt_q     <= '0;
            lim_q     <= '0;
            gap_q     <= '0;
        end else begin
            state_q   <= state_d;
            owner_q   <= owner_d;
            xip_gnt_q <= xip_gnt_d;
            ind_gnt_q <= ind_gnt_d;
            cmd_q     <= cmd_d;
            addr_q    <= addr_d;
            len_q     <= len_d;
            cnt_q     <= cnt_d;
            lim_q     <= lim_d;
            gap_q     <= gap_d;
        end
    end

    assign xip_gnt   = xip_gnt_q;
    assign ind_gnt   = ind_gnt_q;
    assign seq_start = (state_q == ST_LAUNCH);
    assign seq_cmd   = cmd_q;
    assign seq_addr  = addr_q;
    assign seq_len   = len_q;
    assign xip_done  = done_hit && (owner_q == OWN_XIP);
    assign ind_done  = done_hit && (owner_q == OWN_IND);
    assign xfer_err  = tmo_hit;
    assign seq_abort = tmo_hit;

endmodule

// File: tb/tb_qspi_xfer_arbiter.sv
// Directed bench for qspi_xfer_arbiter.
// Drives and samples 2 time units after each rising edge.
module tb_qspi_xfer_arbiter;

    logic        h_clk;
    logic        h_rst;
    logic        xip_req;
    logic [31:0] xip_addr;
    logic [7:0]  xip_len;
    logic        ind_req;
    logic [7:0]  ind_cmd;
    logic [31:0] ind_addr;
    logic [7:0]  ind_len;
    logic        xip_gnt;
    logic        ind_gnt;
    logic        xip_done;
    logic        ind_done;
    logic        xfer_err;
    logic        seq_start;
    logic [7:0]  seq_cmd;
    logic [31:0] seq_addr;
    logic [7:0]  seq_len;
    logic        seq_busy;
    logic        seq_done;
    logic        seq_abort;
    logic [3:0]  cs_gap;
    logic [15:0] to_lim;

    int n_cmp = 0;
    int n_err = 0;

    qspi_xfer_arbiter dut (
        .h_clk     (h_clk),
        .h_rst     (h_rst),
        .xip_req   (xip_req),
        .xip_addr  (xip_addr),
        .xip_len   (xip_len),
        .ind_req   (ind_req),
        .ind_cmd   (ind_cmd),
        .ind_addr  (ind_addr),
        .ind_len   (ind_len),
        .xip_gnt   (xip_gnt),
        .ind_gnt   (ind_gnt),
        .xip_done  (xip_done),
        .ind_done  (ind_done),
        .xfer_err  (xfer_err),
        .seq_start (seq_start),
        .seq_cmd   (seq_cmd),
        .seq_addr  (seq_addr),
        .seq_len   (seq_len),
        .seq_busy  (seq_busy),
        .seq_done  (seq_done),
        .seq_abort (seq_abort),
        .cs_gap    (cs_gap),
        .to_lim    (to_lim)
    );

    initial h_clk = 1'b0;
    always #5 h_clk = ~h_clk;

    task automatic tick();
        @(posedge h_clk);
        #2;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Returns {ind_gnt, xip_gnt} of the first grant, 0 if none in budget.
    task automatic wait_gnt(output logic [1:0] g);
        g = 2'b00;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (xip_gnt || ind_gnt) begin
                g = {ind_gnt, xip_gnt};
                break;
            end
        end
    endtask

    task automatic count_to_gnt(output int n);
        n = 0;
        for (int i = 0; i < 30; i++) begin
            tick();
            n++;
            if (xip_gnt || ind_gnt) break;
        end
    endtask

    // Starts in the grant cycle; ends one cycle after the done cycle.
    task automatic finish_xfer(output logic xd, output logic id);
        tick();
        tick();
        seq_busy = 1'b1;
        tick();
        seq_done = 1'b1;
        #1;
        xd = xip_done;
        id = ind_done;
        tick();
        seq_done = 1'b0;
        seq_busy = 1'b0;
    endtask

    logic [1:0]  g;
    logic        xd;
    logic        id;
    logic        early;
    logic [1:0]  rr_exp [4];
    int          n;

    initial begin
        h_rst    = 1'b1;
        xip_req  = 1'b0;
        xip_addr = '0;
        xip_len  = '0;
        ind_req  = 1'b0;
        ind_cmd  = '0;
        ind_addr = '0;
        ind_len  = '0;
        seq_busy = 1'b0;
        seq_done = 1'b0;
        cs_gap   = '0;
        to_lim   = '0;
        tick();
        tick();
        chk("rst_pulses", 32'({xip_gnt, ind_gnt, xip_done, ind_done,
                              xfer_err, seq_start, seq_abort}), 32'd0);
        chk("rst_cmd", 32'(seq_cmd), 32'd0);
        chk("rst_addr", seq_addr, 32'd0);
        chk("rst_len", 32'(seq_len), 32'd0);
        h_rst = 1'b0;

        // Single XIP read.
        xip_req  = 1'b1;
        xip_addr = 32'h0000_1000;
        xip_len  = 8'd3;
        tick();
        chk("xip_gnt", 32'({ind_gnt, xip_gnt, seq_start}), 32'b010);
        xip_req = 1'b0;
        tick();
        chk("xip_start", 32'({xip_gnt, seq_start}), 32'b01);
        chk("xip_cmd", 32'(seq_cmd), 32'hEB);
        chk("xip_addr", seq_addr, 32'h0000_1000);
        chk("xip_len", 32'(seq_len), 32'd3);
        tick();
        chk("xip_start_off", 32'(seq_start), 32'd0);
        seq_busy = 1'b1;
        tick();
        seq_done = 1'b1;
        #1;
        chk("xip_done", 32'({xip_done, ind_done, xfer_err}), 32'b100);
        tick();
        seq_done = 1'b0;
        seq_busy = 1'b0;
        #1;
        chk("xip_done_off", 32'(xip_done), 32'd0);

        // Round robin with both requests held after a fresh reset.
        h_rst    = 1'b1;
        xip_req  = 1'b1;
        ind_req  = 1'b1;
        ind_cmd  = 8'h02;
        ind_addr = 32'h0000_0800;
        tick();
        h_rst = 1'b0;
        rr_exp[0] = 2'b01;
        rr_exp[1] = 2'b10;
        rr_exp[2] = 2'b01;
        rr_exp[3] = 2'b10;
        for (int i = 0; i < 4; i++) begin
            wait_gnt(g);
            chk($sformatf("rr_%0d", i), 32'(g), 32'(rr_exp[i]));
            if (i == 3) begin
                xip_req = 1'b0;
                ind_req = 1'b0;
            end
            finish_xfer(xd, id);
        end
        chk("rr_last_done", 32'({xd, id}), 32'b01);

        // Timeout with busy held and no done.
        to_lim   = 16'd10;
        ind_cmd  = 8'h9F;
        ind_addr = 32'h0000_2000;
        ind_len  = 8'd0;
        ind_req  = 1'b1;
        wait_gnt(g);
        chk("to_gnt", 32'(g), 32'b10);
        ind_req = 1'b0;
        tick();
        chk("to_start", 32'(seq_start), 32'd1);
        chk("to_cmd", 32'(seq_cmd), 32'h9F);
        seq_busy = 1'b1;
        early = 1'b0;
        for (int k = 1; k < 10; k++) begin
            tick();
            early = early | xfer_err | seq_abort | ind_done | xip_done;
        end
        chk("to_early", 32'(early), 32'd0);
        tick();
        chk("to_err", 32'({xfer_err, seq_abort, ind_done}), 32'b110);
        tick();
        chk("to_idle", 32'({xfer_err, seq_abort}), 32'd0);
        seq_busy = 1'b0;

        // Done arriving on the timeout cycle.
        to_lim   = 16'd3;
        xip_addr = 32'h0000_6000;
        xip_req  = 1'b1;
        wait_gnt(g);
        chk("tie_gnt", 32'(g), 32'b01);
        xip_req = 1'b0;
        tick();
        seq_busy = 1'b1;
        tick();
        tick();
        chk("tie_pre", 32'(xfer_err), 32'd0);
        tick();
        chk("tie_tmo", 32'({xfer_err, seq_abort}), 32'b11);
        seq_done = 1'b1;
        #1;
        chk("tie_done", 32'({xip_done, xfer_err, seq_abort}), 32'b100);
        tick();
        seq_done = 1'b0;
        seq_busy = 1'b0;
        to_lim   = 16'd0;

        // Inter-transfer gap of 5, then 0.
        cs_gap   = 4'd5;
        ind_cmd  = 8'h0B;
        ind_addr = 32'h0000_3000;
        ind_len  = 8'd7;
        ind_req  = 1'b1;
        wait_gnt(g);
        chk("gap_gnt1", 32'(g), 32'b10);
        ind_addr = 32'h0000_4000;
        finish_xfer(xd, id);
        chk("gap_done1", 32'({xd, id}), 32'b01);
        count_to_gnt(n);
        // done -> 5 GAP cycles -> IDLE pick -> grant
        chk("gap5_cycles", 32'(n + 1), 32'd7);
        chk("gap5_addr", seq_addr, 32'h0000_4000);
        cs_gap = 4'd0;
        finish_xfer(xd, id);
        chk("gap_done2", 32'({xd, id}), 32'b01);
        count_to_gnt(n);
        chk("gap0_cycles", 32'(n + 1), 32'd2);
        ind_req = 1'b0;
        finish_xfer(xd, id);
        chk("gap_done3", 32'({xd, id}), 32'b01);

        // Reset during ACTIVE with an indirect request waiting.
        ind_cmd  = 8'h38;
        ind_addr = 32'h0000_5000;
        ind_len  = 8'd1;
        ind_req  = 1'b1;
        wait_gnt(g);
        chk("mrst_gnt", 32'(g), 32'b10);
        tick();
        tick();
        seq_busy = 1'b1;
        tick();
        h_rst = 1'b1;
        tick();
        chk("mrst_pulses", 32'({xip_gnt, ind_gnt, xip_done, ind_done,
                               xfer_err, seq_start, seq_abort}), 32'd0);
        chk("mrst_cmd", 32'(seq_cmd), 32'd0);
        chk("mrst_addr", seq_addr, 32'd0);
        chk("mrst_len", 32'(seq_len), 32'd0);
        h_rst    = 1'b0;
        seq_busy = 1'b0;
        wait_gnt(g);
        chk("mrst_regnt", 32'(g), 32'b10);
        chk("mrst_addr2", seq_addr, 32'h0000_5000);
        ind_req = 1'b0;
        finish_xfer(xd, id);
        chk("mrst_done", 32'({xd, id}), 32'b01);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/qspi_xfer_arbiter.md
QSPI_XFER_ARBITER -- requirements
Module: qspi_xfer_arbiter

Interface
REQ-001 One clock; reset is synchronous and active-high. All ports and state are sampled and updated on the rising edge of h_clk.
REQ-002 h_clk  in  1  system clock.
REQ-003 h_rst  in  1  synchronous active-high reset.
REQ-004 xip_req  in  1  XIP read request; xip_addr  in  32  XIP byte address; xip_len  in  8  beats minus one.
REQ-005 ind_req  in  1  indirect command request; ind_cmd  in  8  flash opcode; ind_addr  in  32  address; ind_len  in  8  beats minus one.
REQ-006 xip_gnt, ind_gnt  out  1  each  one-cycle grant pulses; xip_done, ind_done  out  1  each  completion pulses; xfer_err  out  1  timeout pulse.
REQ-007 seq_start  out  1  launch pulse to the QSPI controller; seq_cmd  out  8; seq_addr  out  32; seq_len  out  8  (held stable from LAUNCH until IDLE).
REQ-008 seq_busy  in  1  controller busy level; seq_done  in  1  controller completion pulse; seq_abort  out  1  one-cycle abort pulse.
REQ-009 cs_gap  in  4  minimum idle cycles between transfers; to_lim  in  16  timeout limit in cycles (0 = disabled).
REQ-010 Parameter XIP_CMD, default 8'hEB, meaning opcode driven on seq_cmd for XIP transfers.

Function
REQ-011 FSM states: IDLE, LAUNCH, WAIT_ACK, ACTIVE, GAP.
REQ-012 IDLE: if any request is high, the FSM selects a winner, pulses its gnt, captures its cmd/addr/len into the seq_* registers, and enters LAUNCH on the next edge.
REQ-013 Arbitration is 2-way round robin: when both requests are high, the requester not served last wins; when one request is high, it wins.
REQ-014 seq_start is high for exactly the one cycle spent in LAUNCH; the FSM then enters WAIT_ACK.
REQ-015 WAIT_ACK -> ACTIVE when seq_busy=1. WAIT_ACK -> GAP with the owner's done pulse when seq_done=1 arrives before busy.
REQ-016 ACTIVE -> GAP on seq_done=1; in the same cycle the owner's done pulse (xip_done or ind_done) is high.
REQ-017 Timeout counter clears in LAUNCH and increments each cycle in WAIT_ACK/ACTIVE.
REQ-018 If to_lim != 0 and count reaches to_lim, xfer_err and seq_abort pulse for one cycle, no done pulse is issued, and the FSM enters GAP.
REQ-019 seq_done and timeout in the same cycle: done wins, no error.
REQ-020 GAP lasts exactly cs_gap cycles, latched on GAP entry; cs_gap=0 means GAP is skipped and the FSM goes directly to IDLE.
REQ-021 Requests seen during GAP are not granted until IDLE.
REQ-022 A requester holds req and payload until gnt. A req dropped before gnt is never granted.
REQ-023 Grant-to-start latency is 1 cycle. Back-to-back transfer spacing is at least cs_gap+3 cycles, measured from done to the next seq_start.
REQ-024 seq_busy deasserting without seq_done while in ACTIVE is ignored; only done or timeout exits ACTIVE.
REQ-025 to_lim and cs_gap changes take effect at the next LAUNCH and GAP entry respectively.

Reset
REQ-026 On h_rst: state=IDLE, all outputs 0 (seq_cmd/addr/len=0), timeout and gap counters=0, last-served=IND so XIP wins the first tie.
REQ-027 Reset asserted mid-transfer aborts silently: no done, err or abort pulse; outputs are 0 on the cycle after the reset edge.

Structure
REQ-028 Shared package qspi_pkg holds the state enum, the owner enum (OWN_XIP, OWN_IND), XIP_CMD default, and the width constants (CMD 8, ADDR 32, LEN 8, TO 16).
REQ-029 One sub-module qspi_rr_arb implements the 2-way round robin (req[1:0], advance, gnt_onehot[1:0]); FSM, counters and payload registers live in qspi_xfer_arbiter.

Verification
REQ-030 xip_req=1 with addr=32'h0000_1000, len=3 -> xip_gnt next edge, seq_start following cycle with seq_cmd=8'hEB, seq_addr=32'h1000; seq_busy then seq_done -> xip_done same cycle as seq_done.
REQ-031 Both requests high continuously after reset -> grant order XIP, IND, XIP, IND across 4 transfers.
REQ-032 to_lim=16'd10, seq_busy=1, seq_done never asserted -> xfer_err and seq_abort pulse 10 cycles after LAUNCH, no done pulse, FSM back to IDLE.
REQ-033 cs_gap=4'd5, two queued IND requests -> exactly 5 GAP cycles between ind_done and the second ind_gnt, cs_gap=0 -> none.
REQ-034 h_rst asserted during ACTIVE -> all outputs 0 next cycle, no pulses; after release a waiting ind_req is granted normally.
REQ-035 seq_done coincident with the timeout cycle -> done pulse, xfer_err stays 0.
